mux_scan_sequencer: RTL and testbench

//   Upstream controller for the 4-to-1 mux stage. On a start request it drives the
//   mux's active-low enable and 2-bit select through channels 0..3 in order.

---
 rtl/mux_scan_sequencer.sv | 156 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a 4-to-1 mux through channels 0..3 after a start
// request, waits SETTLE_CYCLES on each channel, samples the mux output, and
// publishes the 4-bit word with a one-cycle done pulse.
// Optional feature macro: MUX_SCAN_CHANGE_DETECT_EN adds changeMask/changed,
// reporting which bits differ from the previous completed scan.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       start,
  input  logic       abortScan,
  input  logic       muxY,
  output logic       muxEnableN,
  output logic [1:0] signal,
  output logic       busy,
  output logic       done,
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  output logic [3:0] changeMask,
  output logic       changed,
`endif
  output logic [3:0] scanData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter reload: SETTLE lasts exactly SETTLE_CYCLES cycles because it
  // exits on the edge where the counter is already zero.
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] shadow_q;
  logic       mux_en_n_q;
  logic [1:0] signal_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] scan_data_q;

  // Final word as it stands at the DONE-entry edge: channel 3 is being
  // sampled on that same edge, so its bit comes straight from muxY.
  logic [3:0] shadow_final_d;
  assign shadow_final_d = {muxY, shadow_q[2:0]};

`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic [3:0] prev_data_q;
  logic [3:0] change_mask_q;
  logic       changed_q;
  logic [3:0] change_mask_d;
  assign change_mask_d = shadow_final_d ^ prev_data_q;
`endif

  // Scan sequencer FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shadow_q    <= 4'd0;
      mux_en_n_q  <= 1'b1;
      signal_q    <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_data_q <= 4'd0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      prev_data_q   <= 4'd0;
      change_mask_q <= 4'd0;
      changed_q     <= 1'b0;
`endif
    end else begin
      // Pulses default low; only the DONE-entry edge raises them.
      done_q <= 1'b0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      changed_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          // Abort held in IDLE takes priority over a start request.
          if (start && !abortScan) begin
            state_q    <= SETTLE;
            signal_q   <= 2'd0;
            mux_en_n_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_RELOAD;
          end
        end
        SETTLE: begin
          if (abortScan) begin
            state_q    <= IDLE;
            mux_en_n_q <= 1'b1;
            signal_q   <= 2'd0;
            busy_q     <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SAMPLE: begin
          if (abortScan) begin
            // An abort on the final sample edge discards the scan entirely:
            // no done, and no published or change-detect state moves.
            state_q    <= IDLE;
            mux_en_n_q <= 1'b1;
            signal_q   <= 2'd0;
            busy_q     <= 1'b0;
          end else begin
            shadow_q[signal_q] <= muxY;
            if (signal_q != 2'd3) begin
              signal_q <= signal_q + 2'd1;
              cnt_q    <= CNT_RELOAD;
              state_q  <= SETTLE;
            end else begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              scan_data_q <= shadow_final_d;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
              change_mask_q <= change_mask_d;
              changed_q     <= |change_mask_d;
              prev_data_q   <= shadow_final_d;
`endif
            end
          end
        end
        DONE: begin
          // DONE always lasts one cycle; an abort here ends it the same way.
          state_q    <= IDLE;
          mux_en_n_q <= 1'b1;
          signal_q   <= 2'd0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          mux_en_n_q <= 1'b1;
          signal_q   <= 2'd0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign muxEnableN = mux_en_n_q;
  assign signal     = signal_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign scanData   = scan_data_q;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  assign changeMask = change_mask_q;
  assign changed    = changed_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: runs an S=2 and an S=1 instance side by side
// against a timeline model (cycles since the accepting edge) and adds literal
// expectations for latency, scan words and done counts.
module tb_mux_scan_sequencer;

  localparam int SS[2] = '{2, 1};

  logic clock = 1'b0;
  logic resetN, start, abortScan;
  logic [3:0] data;

  logic       en_o[2];
  logic [1:0] sig_o[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic [3:0] scan_o[2];
  logic       my[2];
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic [3:0] cm_o[2];
  logic       ch_o[2];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model: k = cycles since the accepting edge (1..L while active), -1 idle
  int         mk[2];
  logic [3:0] mscan[2];
  logic [3:0] mprev[2];
  logic [3:0] mmask[2];

  int         done_cnt[2];
  int         done_cyc[2];
  logic       last_chg;
  logic [3:0] last_mask;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign my[gi] = !en_o[gi] ? data[sig_o[gi]] : 1'b0;
    mux_scan_sequencer #(.SETTLE_CYCLES(SS[gi])) dut (
      .clock(clock),
      .resetN(resetN),
      .start(start),
      .abortScan(abortScan),
      .muxY(my[gi]),
      .muxEnableN(en_o[gi]),
      .signal(sig_o[gi]),
      .busy(busy_o[gi]),
      .done(done_o[gi]),
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      .changeMask(cm_o[gi]),
      .changed(ch_o[gi]),
`endif
      .scanData(scan_o[gi])
    );
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model update on each rising edge.
  always @(posedge clock) begin
    cyc++;
    for (int n = 0; n < 2; n++) begin
      int l;
      l = 4 * (SS[n] + 1) + 1;
      if (!resetN) begin
        mk[n] = -1; mscan[n] = 0; mprev[n] = 0; mmask[n] = 0;
      end else if (mk[n] < 0) begin
        if (start && !abortScan) mk[n] = 1;
      end else if (abortScan || mk[n] == l) begin
        mk[n] = -1;
      end else begin
        if (mk[n] == l - 1) begin
          mscan[n] = data;
          mmask[n] = data ^ mprev[n];
          mprev[n] = data;
        end
        mk[n]++;
      end
    end
  end

  // Compare process: all outputs of both instances every cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        int l;
        logic act;
        logic [1:0] esig;
        l = 4 * (SS[n] + 1) + 1;
        act = (mk[n] >= 1);
        esig = !act ? 2'd0 : (mk[n] == l) ? 2'd3 : 2'((mk[n] - 1) / (SS[n] + 1));
        check($sformatf("enN%0d", n), {7'd0, en_o[n]}, {7'd0, !act});
        check($sformatf("signal%0d", n), {6'd0, sig_o[n]}, {6'd0, esig});
        check($sformatf("busy%0d", n), {7'd0, busy_o[n]}, {7'd0, act});
        check($sformatf("done%0d", n), {7'd0, done_o[n]}, {7'd0, mk[n] == l});
        check($sformatf("scanData%0d", n), {4'd0, scan_o[n]}, {4'd0, mscan[n]});
`ifdef MUX_SCAN_CHANGE_DETECT_EN
        check($sformatf("changeMask%0d", n), {4'd0, cm_o[n]}, {4'd0, mmask[n]});
        check($sformatf("changed%0d", n), {7'd0, ch_o[n]},
              {7'd0, (mk[n] == l) && (mmask[n] != 0)});
`endif
        if (done_o[n]) begin
          done_cnt[n]++;
          done_cyc[n] = cyc;
          $display("scan dut%0d done cyc=%0d scanData=%b", n, cyc, scan_o[n]);
          if (n == 0) begin
`ifdef MUX_SCAN_CHANGE_DETECT_EN
            last_chg  = ch_o[0];
            last_mask = cm_o[0];
`endif
          end
        end
      end
    end
  end

  int e_cyc;

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 e_cyc = cyc;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic scan(input logic [3:0] d);
    @(negedge clock); data = d;
    pulse_start();
    repeat (16) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int n = 0; n < 2; n++) begin
      check({tag, "_enN"}, {7'd0, en_o[n]}, 8'd1);
      check({tag, "_sig"}, {6'd0, sig_o[n]}, 8'd0);
      check({tag, "_busy"}, {7'd0, busy_o[n]}, 8'd0);
      check({tag, "_done"}, {7'd0, done_o[n]}, 8'd0);
      check({tag, "_scan"}, {4'd0, scan_o[n]}, 8'd0);
    end
  endtask

  initial begin
    int c0, c1;
    resetN = 1'b0; start = 1'b0; abortScan = 1'b0; data = 4'd0;
    mk = '{-1, -1}; mscan = '{0, 0}; mprev = '{0, 0}; mmask = '{0, 0};
    done_cnt = '{0, 0}; done_cyc = '{0, 0};
    last_chg = 1'b0; last_mask = 4'd0;

    // 1: reset for two edges
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    chk_en = 1'b1;
    check_reset_vals("reset");

    // 2: single scan, data 1010
    c0 = done_cnt[0]; c1 = done_cnt[1];
    scan(4'b1010);
    check("lat_s2", 8'(done_cyc[0] - e_cyc), 8'd12);
    check("lat_s1", 8'(done_cyc[1] - e_cyc), 8'd8);
    check("scan1_s2", {4'd0, scan_o[0]}, 8'b1010);
    check("scan1_s1", {4'd0, scan_o[1]}, 8'b1010);
    check("ndone1", 8'(done_cnt[0] - c0), 8'd1);
    check("ndone1_s1", 8'(done_cnt[1] - c1), 8'd1);

    // 3: start held high for 42 edges, data 0110
    @(negedge clock); data = 4'b0110;
    c0 = done_cnt[0]; c1 = done_cnt[1];
    @(negedge clock); start = 1'b1;
    repeat (42) @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (20) @(negedge clock);
    check("bb_dones_s2", 8'(done_cnt[0] - c0), 8'd3);
    check("bb_dones_s1", 8'(done_cnt[1] - c1), 8'd5);
    check("bb_scan_s1", {4'd0, scan_o[1]}, 8'b0110);

    // 4: abort during channel 2 settle, then reset mid-scan
    scan(4'b1010);
    @(negedge clock); data = 4'b0101;
    c0 = done_cnt[0];
    pulse_start();
    repeat (6) @(negedge clock);
    abortScan = 1'b1;
    @(negedge clock); abortScan = 1'b0;
    check("abort_enN", {7'd0, en_o[0]}, 8'd1);
    check("abort_busy", {7'd0, busy_o[0]}, 8'd0);
    repeat (20) @(negedge clock);
    check("abort_nodone", 8'(done_cnt[0] - c0), 8'd0);
    check("abort_keep", {4'd0, scan_o[0]}, 8'b1010);

    pulse_start();
    repeat (5) @(negedge clock);
    resetN = 1'b0;
    @(negedge clock); resetN = 1'b1;
    check_reset_vals("midreset");

    // abort wins over start in IDLE
    @(negedge clock); start = 1'b1; abortScan = 1'b1;
    @(negedge clock); start = 1'b0; abortScan = 1'b0;
    check("idle_abort_busy", {7'd0, busy_o[0]}, 8'd0);

    // 5: change detection sequence (scanData checks also run in default build)
    scan(4'b1010);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("cd1_mask", {4'd0, last_mask}, 8'b1010);
    check("cd1_chg", {7'd0, last_chg}, 8'd1);
`endif
    scan(4'b0011);
    check("cd2_scan", {4'd0, scan_o[0]}, 8'b0011);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("cd2_mask", {4'd0, last_mask}, 8'b1001);
    check("cd2_chg", {7'd0, last_chg}, 8'd1);
`endif
    scan(4'b0011);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("cd3_mask", {4'd0, last_mask}, 8'b0000);
    check("cd3_chg", {7'd0, last_chg}, 8'd0);
`endif

    // 6: S=1 instance with data 0110
    scan(4'b0110);
    check("s1_lat", 8'(done_cyc[1] - e_cyc), 8'd8);
    check("s1_scan", {4'd0, scan_o[1]}, 8'b0110);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
